// File: rtl/store_outstanding_ctrl.sv
// store_outstanding_ctrl
// Issue-side controller for store traffic toward the write-through memory port.
// Tracks in-flight stores against a cap, isolates stores to non-idempotent
// regions so they run with nothing else in flight, and sequences fence drains.
module store_outstanding_ctrl #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
  parameter int unsigned NrNonIdemRules = 2,
  parameter logic [NrNonIdemRules-1:0][AddrWidth-1:0] NonIdemBase   = '0,
  parameter logic [NrNonIdemRules-1:0][AddrWidth-1:0] NonIdemLength = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  input  logic                 mem_ack_i,
  input  logic                 fence_i,
  output logic                 fence_done_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 empty_o,
  output logic                 underflow_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  typedef enum logic [1:0] {
    StIdle,
    StNcAck,
    StDrain
  } state_e;

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                fence_pend_q;
  logic                fence_done_q;
  logic                underflow_q;

  logic                nc;
  logic                allow;
  logic                issue;
  logic                ack_dec;
  logic                ack_under;

  // Non-idempotent region lookup; an end address that overflows the address
  // space disables the rule rather than wrapping around to low addresses.
  always_comb begin
    logic [AddrWidth:0] end_w;
    nc    = 1'b0;
    end_w = '0;
    for (int unsigned i = 0; i < NrNonIdemRules; i++) begin
      end_w = {1'b0, NonIdemBase[i]} + {1'b0, NonIdemLength[i]};
      if ((NonIdemLength[i] != '0) && !end_w[AddrWidth] &&
          (req_addr_i >= NonIdemBase[i]) &&
          (req_addr_i <  end_w[AddrWidth-1:0])) begin
        nc = 1'b1;
      end
    end
  end

  // Issue gate: only in idle, never alongside a fence, below the cap, and a
  // non-idempotent store only when nothing else is in flight.
  always_comb begin
    allow = (state_q == StIdle) && !fence_i && (cnt_q < MaxCnt) &&
            (!nc || (cnt_q == '0));
    mem_valid_o = req_valid_i & allow;
    req_ready_o = mem_ready_i & allow;
    issue       = mem_valid_o & mem_ready_i;
    ack_dec     = mem_ack_i & (cnt_q != '0);
    ack_under   = mem_ack_i & (cnt_q == '0);
  end

  // Next in-flight count; a simultaneous issue and ack cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && !ack_dec) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (!issue && ack_dec) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  // Control FSM, in-flight counter and registered status outputs.
  // fence_done_q is loaded one cycle early so that it is high exactly while
  // the FSM sits in DRAIN with an empty counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fence_pend_q <= 1'b0;
      fence_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      underflow_q  <= underflow_q | ack_under;
      fence_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (fence_i) begin
            state_q      <= StDrain;
            fence_done_q <= (cnt_d == '0);
          end else if (issue && nc) begin
            state_q <= StNcAck;
          end
        end
        StNcAck: begin
          if (fence_i) begin
            fence_pend_q <= 1'b1;
          end
          if (cnt_d == '0) begin
            if (fence_pend_q || fence_i) begin
              state_q      <= StDrain;
              fence_done_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDrain: begin
          if (cnt_q == '0) begin
            state_q      <= StIdle;
            fence_pend_q <= 1'b0;
          end else begin
            fence_done_q <= (cnt_d == '0);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign fence_done_o  = fence_done_q;
  assign outstanding_o = cnt_q;
  assign empty_o       = (cnt_q == '0);
  assign underflow_o   = underflow_q;

endmodule
